seven_seg_scan: RTL and testbench

//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display (active-low seg/anode).

---
 rtl/seven_seg_scan.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan
// Brief   : Time-multiplexed common-anode 7-segment driver with per-digit DP,
//           per-digit blanking, anti-ghost blanking gap and whole-display blink.
// Revision: 1.0
// ============================================================================
module seven_seg_scan #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 100000,
    parameter  int BLANK_CYCLES = 1000,
    parameter  int HEX_MODE     = 0,
    parameter  int BLINK_SCANS  = 50,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    blink_en,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  C_BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0] C_SCAN_LAST = SCAN_W'(BLINK_SCANS - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [SCAN_W-1:0]         r_scan;
    logic                      r_phase_on;
    logic [4*NUM_DIGITS-1:0]   r_sh_digits;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic [NUM_DIGITS-1:0]     r_sh_blank;
    logic [7:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_an;

    logic                      w_slot_end;
    logic                      w_last_digit;
    logic [3:0]                w_cur_code;
    logic                      w_cur_dp;
    logic                      w_cur_blank;
    logic                      w_an_active;
    logic [NUM_DIGITS-1:0]     w_an_next;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] pat;
        pat = 7'h7F;
        case (code)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
            4'hB: pat = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
            4'hC: pat = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
            4'hD: pat = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
            4'hE: pat = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
            4'hF: pat = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign w_slot_end   = (r_cnt == C_CNT_LAST);
    assign w_last_digit = (r_idx == C_IDX_LAST);

    always_comb begin
        w_cur_code  = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_code  = r_sh_digits[4*i +: 4];
                w_cur_dp    = r_sh_dp[i];
                w_cur_blank = r_sh_blank[i];
            end
        end
    end

    // Anodes stay off during the first BLANK_CYCLES of each slot so the previous
    // digit's segment pattern never ghosts onto the newly selected anode.
    assign w_an_active = (r_cnt >= C_BLANK_END) && !w_cur_blank && (r_phase_on || !blink_en);

    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_an_active && (r_idx == IDX_W'(i))) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan     <= '0;
            r_phase_on <= 1'b1;
        end else if (!blink_en) begin
            r_scan     <= '0;
            r_phase_on <= 1'b1;
        end else if (w_slot_end && w_last_digit) begin
            if (r_scan == C_SCAN_LAST) begin
                r_scan     <= '0;
                r_phase_on <= ~r_phase_on;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
        end else if (load) begin
            r_sh_digits <= digits_in;
            r_sh_dp     <= dp_in;
            r_sh_blank  <= blank_in;
        end
    end

    // Segment pattern is refreshed once per slot, even for dark digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else begin
            if (r_cnt == '0) begin
                r_seg <= {~w_cur_dp, f_decode(w_cur_code)};
            end
            r_an <= w_an_next;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scan
// Brief   : Directed self-checking bench; HEX_MODE=0 and HEX_MODE=1 instances
//           share stimulus. Revision: 1.0
// ============================================================================
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        blink_en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic [1:0]  idx0, idx1;

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(0), .BLINK_SCANS(BS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .blink_en(blink_en), .seg(seg0), .an(an0), .digit_idx(idx0)
    );

    seven_seg_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(1), .BLINK_SCANS(BS)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .blink_en(blink_en), .seg(seg1), .an(an1), .digit_idx(idx1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk);
        digits_in = d;
        dp_in     = dp;
        blank_in  = blk;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        tick();
    endtask

    // k counts edges since reset release: after edge k the slot counter is k%8,
    // while seg/an reflect the slot state of edge k-1.
    task automatic check_scan(input int nslots, input logic [31:0] e_seg,
                              input logic [31:0] e_hex, input logic [3:0] blk, input bit dark);
        int         s;
        logic [3:0] e_an;
        while ((k % RD) != 1) tick();
        repeat (nslots * RD) begin
            s    = ((k - 1) / RD) % N;
            e_an = 4'hF;
            if ((((k - 1) % RD) >= BC) && !blk[s] && !dark) e_an[s] = 1'b0;
            chk_eq("seg",     seg0, e_seg[s*8 +: 8]);
            chk_eq("seg_hex", seg1, e_hex[s*8 +: 8]);
            chk_eq("an",      an0,  e_an);
            chk_eq("idx",     idx0, (k / RD) % N);
            tick();
        end
    endtask

    initial begin
        int         s;
        logic [7:0] old_seg;
        logic [31:0] old_tbl;

        rst_n     = 1'b0;
        load      = 1'b0;
        blink_en  = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_in  = '0;

        @(negedge clk);
        @(negedge clk);
        chk_eq("rst_seg",     seg0, 8'hFF);
        chk_eq("rst_seg_hex", seg1, 8'hFF);
        chk_eq("rst_an",      an0,  4'hF);
        chk_eq("rst_an_hex",  an1,  4'hF);
        chk_eq("rst_idx",     idx0, 2'd0);
        rst_n = 1'b1;
        k     = 0;

        // No load yet: shadow blank is all ones, digit 0 code shows but stays dark.
        check_scan(12, 32'hC0C0C0C0, 32'hC0C0C0C0, 4'hF, 1'b0);

        do_load(16'h1234, 4'b0100, 4'b0000);
        check_scan(4, 32'hF924B099, 32'hF924B099, 4'b0000, 1'b0);

        do_load(16'hABCD, 4'b0000, 4'b0000);
        check_scan(4, 32'hFFFFFFFF, 32'h8883C6A1, 4'b0000, 1'b0);

        do_load(16'h1234, 4'b0100, 4'b1010);
        check_scan(4, 32'hF924B099, 32'hF924B099, 4'b1010, 1'b0);

        // Load mid-slot: current pattern must hold until the slot wraps.
        old_tbl = 32'hF924B099;
        tick();
        tick();
        digits_in = 16'h8888;
        dp_in     = 4'b0000;
        blank_in  = 4'b0000;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        s         = ((k - 1) / RD) % N;
        old_seg   = old_tbl[s*8 +: 8];
        while ((k % RD) != 1) begin
            chk_eq("seg_hold", seg0, old_seg);
            tick();
        end
        check_scan(4, 32'h80808080, 32'h80808080, 4'b0000, 1'b0);

        // Blink: 2 scans lit, 2 scans dark; drop blink_en while dark.
        do_load(16'h1234, 4'b0000, 4'b0000);
        while ((k % (RD * N)) != 1) tick();
        blink_en = 1'b1;
        check_scan(8, 32'hF9A4B099, 32'hF9A4B099, 4'b0000, 1'b0);
        check_scan(4, 32'hF9A4B099, 32'hF9A4B099, 4'b0000, 1'b1);
        blink_en = 1'b0;
        check_scan(4, 32'hF9A4B099, 32'hF9A4B099, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a slot.
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_seg",     seg0, 8'hFF);
        chk_eq("mid_rst_seg_hex", seg1, 8'hFF);
        chk_eq("mid_rst_an",      an0,  4'hF);
        chk_eq("mid_rst_idx",     idx0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        check_scan(4, 32'hC0C0C0C0, 32'hC0C0C0C0, 4'hF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
